// File: rtl/tx_serial_arbitro.sv
// tx_serial_arbitro: round-robin arbiter that shares one 7E1 serial transmitter among NREQ requesters,
// with a watchdog that aborts a frame when the transmitter never reports done.
module tx_serial_arbitro #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8191,
    parameter int TW      = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   pedido,
    input  logic [7*NREQ-1:0] dados,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   erro,
    output logic              tx_partida,
    output logic [6:0]        tx_dados,
    input  logic              tx_pronto,
    output logic              ocupado,
    output logic [2:0]        db_concedido,
    output logic [3:0]        db_estado
);
    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        SELECIONA = 4'd1,
        PARTIDA   = 4'd2,
        ESPERA    = 4'd3,
        CONFIRMA  = 4'd4,
        ERRO      = 4'd5
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [2:0]      ptr_q, ptr_d, conc_q, conc_d, busca, prox;
    logic [3:0]      idx;
    logic            busca_ok;
    logic [NREQ-1:0] rot, ack_q, ack_d, erro_q, erro_d;
    logic [6:0]      dados_q, dados_d, sel;
    logic [TW-1:0]   wd_q, wd_d;
    logic            partida_q, partida_d, ocupado_q, ocupado_d;

    // Rotate requests so bit 0 is the pointer position; the lowest set offset wins.
    always_comb begin
        rot = NREQ'({pedido, pedido} >> ptr_q);
        busca = ptr_q;
        busca_ok = 1'b0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = {1'b0, ptr_q} + 4'(i);
                busca = (idx >= 4'(NREQ)) ? 3'(idx - 4'(NREQ)) : idx[2:0];
                busca_ok = 1'b1;
            end
        end
        sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (busca == 3'(i)) sel = dados[7*i +: 7];
        prox = (conc_q == 3'(NREQ - 1)) ? 3'd0 : conc_q + 3'd1;
    end

    always_comb begin
        estado_d = estado_q;
        ptr_d = ptr_q;
        conc_d = conc_q;
        dados_d = dados_q;
        wd_d = wd_q;
        case (estado_q)
            INICIAL:   estado_d = (|pedido) ? SELECIONA : INICIAL;
            SELECIONA: begin
                estado_d = busca_ok ? PARTIDA : INICIAL;
                conc_d = busca_ok ? busca : conc_q;
                dados_d = busca_ok ? sel : dados_q;
            end
            PARTIDA: begin
                wd_d = '0;
                estado_d = ESPERA;
            end
            // tx_pronto takes precedence over an expiring watchdog
            ESPERA: begin
                estado_d = tx_pronto ? CONFIRMA : (wd_q == TW'(TIMEOUT - 1)) ? ERRO : ESPERA;
                wd_d = wd_q + TW'(1);
            end
            CONFIRMA, ERRO: begin
                ptr_d = prox;
                estado_d = INICIAL;
            end
            default:   estado_d = INICIAL;
        endcase
        partida_d = (estado_d == PARTIDA);
        ocupado_d = estado_d inside {PARTIDA, ESPERA, CONFIRMA, ERRO};
        for (int i = 0; i < NREQ; i++) begin
            ack_d[i] = (estado_d == CONFIRMA) && (conc_d == 3'(i));
            erro_d[i] = (estado_d == ERRO) && (conc_d == 3'(i));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= INICIAL;
            ptr_q     <= '0;
            conc_q    <= '0;
            dados_q   <= '0;
            wd_q      <= '0;
            ack_q     <= '0;
            erro_q    <= '0;
            partida_q <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            ptr_q     <= ptr_d;
            conc_q    <= conc_d;
            dados_q   <= dados_d;
            wd_q      <= wd_d;
            ack_q     <= ack_d;
            erro_q    <= erro_d;
            partida_q <= partida_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign ack          = ack_q;
    assign erro         = erro_q;
    assign tx_partida   = partida_q;
    assign tx_dados     = dados_q;
    assign ocupado      = ocupado_q;
    assign db_concedido = conc_q;
    assign db_estado    = estado_q;
endmodule

// File: tb/tb_tx_serial_arbitro.sv
// tb_tx_serial_arbitro: scoreboard bench for tx_serial_arbitro with a simple transmitter model
// answering tx_partida with a tx_pronto pulse after a programmable delay.
module tb_tx_serial_arbitro;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8191;
    localparam int TW      = 13;

    typedef struct packed {
        logic [2:0] idx;
        logic [6:0] ch;
    } start_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] pedido = '0;
    logic [27:0]     dados;
    logic [NREQ-1:0] ack, erro;
    logic            tx_partida;
    logic [6:0]      tx_dados;
    logic            tx_pronto = 1'b0;
    logic            ocupado;
    logic [2:0]      db_concedido;
    logic [3:0]      db_estado;

    logic [6:0] ch [NREQ];
    start_t     exp_start [$];
    logic [7:0] exp_res [$];
    int checks = 0, failures = 0;
    int cyc = 0, starts_seen = 0, last_start_cyc = 0, last_res_cyc = 0, m_ptr = 0;
    int pronto_delay = 20;
    bit auto_pronto = 1'b0, have_start = 1'b0;

    tx_serial_arbitro #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clock(clock), .reset(reset), .pedido(pedido), .dados(dados),
        .ack(ack), .erro(erro), .tx_partida(tx_partida), .tx_dados(tx_dados),
        .tx_pronto(tx_pronto), .ocupado(ocupado), .db_concedido(db_concedido),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always_comb
        for (int i = 0; i < NREQ; i++) dados[7*i +: 7] = ch[i];

    // transmitter model: tx_pronto pulse pronto_delay cycles after a start (negative = never)
    always begin
        @(negedge clock);
        if (auto_pronto && tx_partida && pronto_delay >= 0) begin
            repeat (pronto_delay) @(negedge clock);
            tx_pronto = 1'b1;
            @(negedge clock);
            tx_pronto = 1'b0;
        end
    end

    // scoreboard monitor for start pulses and ack/erro pulses
    always @(negedge clock) begin
        start_t e;
        logic [7:0] r;
        if (tx_partida) begin
            checks++;
            if (exp_start.size() == 0) begin
                failures++;
                $display("FAIL start_unexpected: got grant=%0d char=%h, expected no start", db_concedido, tx_dados);
            end else begin
                e = exp_start.pop_front();
                if ({db_concedido, tx_dados} !== {e.idx, e.ch}) begin
                    failures++;
                    $display("FAIL start_frame: got grant=%0d char=%h, expected grant=%0d char=%h",
                             db_concedido, tx_dados, e.idx, e.ch);
                end
            end
            if (have_start) begin
                checks++;
                if (cyc - last_start_cyc < 4) begin
                    failures++;
                    $display("FAIL start_gap: got %0d cycles, expected >= 4", cyc - last_start_cyc);
                end
            end
            have_start = 1'b1;
            last_start_cyc = cyc;
            starts_seen++;
        end
        if (ack !== '0 || erro !== '0) begin
            checks++;
            last_res_cyc = cyc;
            if (exp_res.size() == 0) begin
                failures++;
                $display("FAIL result_unexpected: got ack=%b erro=%b, expected none", ack, erro);
            end else begin
                r = exp_res.pop_front();
                if ({ack, erro} !== r) begin
                    failures++;
                    $display("FAIL result: got ack=%b erro=%b, expected ack=%b erro=%b", ack, erro, r[7:4], r[3:0]);
                end
            end
        end
    end

    function automatic logic [2:0] pick(input logic [3:0] req, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j = (p + k) % NREQ;
            if (req[j]) return 3'(j);
        end
        return 3'(p);
    endfunction

    task automatic wait_start(input string name);
        int n = 0;
        @(negedge clock);
        while (!tx_partida && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!tx_partida) begin
            checks++;
            failures++;
            $display("FAIL %s_start_timeout: got no tx_partida, expected one within 100 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clock);
        while ((ocupado || exp_start.size() != 0 || exp_res.size() != 0) && n < TIMEOUT + 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (ocupado || exp_start.size() != 0 || exp_res.size() != 0) begin
            failures++;
            $display("FAIL %s_idle: got ocupado=%b pending=%0d/%0d, expected idle", name, ocupado,
                     exp_start.size(), exp_res.size());
        end
    endtask

    // model the expected grant sequence, then hold req until n starts have appeared
    task automatic run_frames(input string name, input logic [3:0] req, input int n, input int delay);
        int base, lim;
        logic [2:0] g;
        auto_pronto = 1'b1;
        pronto_delay = delay;
        for (int k = 0; k < n; k++) begin
            g = pick(req, m_ptr);
            exp_start.push_back({g, ch[g]});
            exp_res.push_back((delay >= 0 && delay <= TIMEOUT) ? {4'(1 << g), 4'b0} : {4'b0, 4'(1 << g)});
            m_ptr = (int'(g) + 1) % NREQ;
        end
        base = starts_seen;
        lim = 0;
        pedido = req;
        while (starts_seen < base + n && lim < n * (TIMEOUT + 50)) begin
            @(negedge clock);
            lim++;
        end
        pedido = '0;
        checks++;
        if (starts_seen != base + n) begin
            failures++;
            $display("FAIL %s_starts: got %0d, expected %0d", name, starts_seen - base, n);
        end
        wait_idle(name);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({ack, erro, tx_partida, tx_dados, ocupado, db_concedido, db_estado} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ack=%b erro=%b st=%b dados=%h oc=%b conc=%0d est=%0d, expected all 0",
                     ack, erro, tx_partida, tx_dados, ocupado, db_concedido, db_estado);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got estado=%0d ocupado=%b, expected 0 0", db_estado, ocupado);
        end
    endtask

    task automatic test_single;
        ch[0] = 7'h41;
        exp_start.push_back({3'd0, 7'h41});
        exp_res.push_back({4'b0001, 4'b0000});
        auto_pronto = 1'b1;
        pronto_delay = 4774;
        pedido = 4'b0001;
        @(negedge clock);
        checks++;
        if (db_estado !== 4'd1) begin
            failures++;
            $display("FAIL single_seleciona: got estado=%0d, expected 1", db_estado);
        end
        wait_start("single");
        pedido = '0;
        wait_idle("single");
        checks++;
        if (last_res_cyc - last_start_cyc != 4775) begin
            failures++;
            $display("FAIL single_ack_latency: got %0d, expected 4775", last_res_cyc - last_start_cyc);
        end
        m_ptr = 1;
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < NREQ; i++) ch[i] = 7'(8'h30 + i);
        run_frames("round_robin", 4'b1111, 5, 20);
    endtask

    task automatic test_timeout;
        run_frames("timeout", 4'b0100, 1, -1);
        checks++;
        if (last_res_cyc - last_start_cyc != TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_latency: got %0d, expected %0d", last_res_cyc - last_start_cyc, TIMEOUT + 1);
        end
    endtask

    task automatic test_fairness;
        run_frames("fairness", 4'b1001, 2, 20);
    endtask

    task automatic test_timeout_boundary;
        run_frames("timeout_edge", 4'b0001, 1, TIMEOUT);
        checks++;
        if (last_res_cyc - last_start_cyc != TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_edge_latency: got %0d, expected %0d", last_res_cyc - last_start_cyc, TIMEOUT + 1);
        end
    endtask

    task automatic test_dados_change;
        ch[2] = 7'h55;
        exp_start.push_back({3'd2, 7'h55});
        exp_res.push_back({4'b0100, 4'b0000});
        auto_pronto = 1'b1;
        pronto_delay = 30;
        pedido = 4'b0100;
        wait_start("dados_change");
        pedido = '0;
        ch[2] = 7'h2A;
        repeat (5) @(negedge clock);
        checks++;
        if (tx_dados !== 7'h55 || db_estado !== 4'd3) begin
            failures++;
            $display("FAIL dados_hold: got char=%h estado=%0d, expected 55 3", tx_dados, db_estado);
        end
        wait_idle("dados_change");
        m_ptr = 3;
    endtask

    task automatic test_stale_pronto;
        auto_pronto = 1'b0;
        exp_start.push_back({3'd1, ch[1]});
        exp_res.push_back({4'b0010, 4'b0000});
        tx_pronto = 1'b1;
        pedido = 4'b0010;
        wait_start("stale");
        tx_pronto = 1'b0;
        pedido = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (db_estado !== 4'd3) begin
                failures++;
                $display("FAIL stale_espera%0d: got estado=%0d, expected 3", k, db_estado);
            end
        end
        tx_pronto = 1'b1;
        @(negedge clock);
        tx_pronto = 1'b0;
        wait_idle("stale");
        m_ptr = 2;
    endtask

    task automatic test_reset_mid_frame;
        auto_pronto = 1'b0;
        exp_start.push_back({3'd3, ch[3]});
        pedido = 4'b1000;
        wait_start("reset_mid");
        pedido = '0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ack, erro, tx_partida, tx_dados, ocupado, db_concedido, db_estado} !== '0) begin
            failures++;
            $display("FAIL reset_async: got ack=%b erro=%b st=%b dados=%h oc=%b conc=%0d est=%0d, expected all 0",
                     ack, erro, tx_partida, tx_dados, ocupado, db_concedido, db_estado);
        end
        @(negedge clock);
        reset = 1'b0;
        m_ptr = 0;
        repeat (2) @(negedge clock);
        run_frames("after_reset", 4'b0110, 1, 10);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) ch[i] = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_fairness;
        test_timeout_boundary;
        test_dados_change;
        test_stale_pronto;
        test_reset_mid_frame;
        repeat (5) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
